// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator: raster-order signed pixels in, valid-mode
// 3x3 neighbourhoods out, with two line buffers holding rows r-1 and r-2.
module conv_window_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic signed [7:0] pix_in,
    input  logic              sof,
    output logic              win_valid,
    output logic signed [7:0] win0,
    output logic signed [7:0] win1,
    output logic signed [7:0] win2,
    output logic signed [7:0] win3,
    output logic signed [7:0] win4,
    output logic signed [7:0] win5,
    output logic signed [7:0] win6,
    output logic signed [7:0] win7,
    output logic signed [7:0] win8,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]   r_col, w_col;
    logic [RW-1:0]   r_row, w_row;
    logic            w_last_col, w_last_row, w_emit;
    logic [7:0]      r_lb0 [IMG_W];
    logic [7:0]      r_lb1 [IMG_W];
    logic [7:0]      w_t0, w_t1;
    logic [1:0][7:0] r_top, r_mid, r_bot;
    logic [8:0][7:0] r_win;
    logic            r_valid, r_done;

    // sof redirects the accepted pixel to (0,0) without a separate state.
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_last_col = (w_col == COL_LAST);
    assign w_last_row = (w_row == ROW_LAST);
    assign w_emit     = pix_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));

    // Combinational read gives the old contents when written the same edge.
    assign w_t1 = r_lb1[w_col];
    assign w_t0 = r_lb0[w_col];

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb0[w_col] <= w_t1;
            r_lb1[w_col] <= pix_in;
        end
    end

    // Column history keeps c-1 in [0] and c-2 in [1]; the incoming column
    // goes straight into the output register, completing the 3-deep window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_top   <= '0;
            r_mid   <= '0;
            r_bot   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_done  <= w_emit && w_last_col && w_last_row;
            if (pix_valid) begin
                r_col <= w_last_col ? '0 : w_col + 1'b1;
                if (w_last_col)
                    r_row <= w_last_row ? '0 : w_row + 1'b1;
                else
                    r_row <= w_row;
                r_top <= {r_top[0], w_t0};
                r_mid <= {r_mid[0], w_t1};
                r_bot <= {r_bot[0], pix_in};
            end
            if (w_emit)
                r_win <= {pix_in, r_bot[0], r_bot[1],
                          w_t1,   r_mid[0], r_mid[1],
                          w_t0,   r_top[0], r_top[1]};
        end
    end

    assign win_valid  = r_valid;
    assign frame_done = r_done;
    assign win0 = r_win[0];
    assign win1 = r_win[1];
    assign win2 = r_win[2];
    assign win3 = r_win[3];
    assign win4 = r_win[4];
    assign win5 = r_win[5];
    assign win6 = r_win[6];
    assign win7 = r_win[7];
    assign win8 = r_win[8];

endmodule

// File: doc/conv_window_3x3.md
# conv_window_3x3

Streaming 3×3 window generator that sits directly upstream of the 3×3 DSP convolution datapath. It accepts signed 8-bit pixels in raster order, one per cycle, and buffers the two previous image rows in line buffers. For every valid output position it presents a complete 3×3 neighbourhood, in0..in8 order, together with a one-cycle valid strobe. It performs valid-mode (no padding) windowing. Frame size is fixed by parameters.

## Interface
- IMG_W, 28: image width in pixels, ≥3
- IMG_H, 28: image height in rows, ≥3
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; single clock domain
- pix_valid  input  1  pixel strobe; pix_in is accepted on every cycle it is high; no backpressure
- pix_in  input  8  signed pixel
- sof  input  1  start of frame; qualified by pix_valid; marks the accepted pixel as (row 0, col 0)
- win_valid  output  1  window strobe, one cycle per output position
- win0..win8  output  8 each  signed window pixels, row-major: win0=(r-2,c-2), win1=(r-2,c-1), win2=(r-2,c), win3=(r-1,c-2) … win8=(r,c)
- frame_done  output  1  one-cycle pulse, coincident with the last window of a frame

## Operation
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1, each $clog2-sized. Both advance only on accepted pixels.
  - col wraps to 0 at IMG_W-1 and row increments.
  - row wraps to 0 after (IMG_H-1, IMG_W-1), so a frame may follow back-to-back without sof.
- sof with pix_valid forces the accepted pixel to (0,0); the counters then continue from (0,1). sof without pix_valid is ignored.
- Two line buffers, lb1 (row r-1) and lb0 (row r-2), each IMG_W×8, addressed by col. On accept at col c:
  - read t1=lb1[c] and t0=lb0[c];
  - write lb0[c]<=t1 and lb1[c]<=pix_in.
  Read-before-write is required at the same address.
- Window is three 3-deep column shift registers. On accept:
  - top row shifts in t0, middle row shifts in t1, bottom row shifts in pix_in;
  - the oldest column is discarded.
- Emit condition: an accepted pixel at row≥2 and col≥2. win_valid is registered and high in the following cycle.
- Windows per frame: (IMG_H-2)*(IMG_W-2), i.e. 676 at defaults.
- frame_done asserts with the window for pixel (IMG_H-1, IMG_W-1).
- Stale data is never exposed. At col<2 and row<2 the shift registers and line buffers hold previous-row or previous-frame data, but the emit gating suppresses it. No flush is needed.
- Data is pass-through only, with no arithmetic. Signed values are preserved bit-exactly.

## Timing
- Reset values:
  - win_valid=0, frame_done=0, win0..win8=0;
  - row=0, col=0;
  - window registers 0.
  Line-buffer RAM is not reset; its contents are don't-care.
- Latency: pix_valid cycle N with emit condition true → win_valid=1 and window data in cycle N+1.
- Outputs hold their last value while win_valid=0. Downstream must sample only when win_valid=1.
- Bubbles (pix_valid=0) freeze counters, line buffers and window. Output depends only on the accepted-pixel sequence, not the gap pattern.
- Throughput: one window per cycle in steady state.
- sof mid-frame: the in-progress frame is abandoned. No frame_done is issued for it, and there are no windows until the new frame reaches (2,2).
- Reset mid-frame: outputs clear asynchronously on the falling edge of rst_n. The first pixel after release is (0,0) regardless of sof.
- sof coincident with the wrap from (IMG_H-1, IMG_W-1) is consistent: the pixel is (0,0) either way.

## Test plan
- Basic 4×4 frame, IMG_W=IMG_H=4, pix_in=0..15 contiguous with sof on pixel 0 → exactly 4 windows, each one cycle after its pixel:
  - pixel 10: {0,1,2,4,5,6,8,9,10}
  - pixel 11: {1,2,3,5,6,7,9,10,11}
  - pixel 14: {4,5,6,8,9,10,12,13,14}
  - pixel 15: {5,6,7,9,10,11,13,14,15}, with frame_done=1 on this window only.
- Bubbles: same 4×4 stream with pix_valid toggling 1,0,1,0… → identical 4 windows and frame_done. win_valid is never high in two consecutive cycles.
- Back-to-back frames: two 4×4 frames without a gap, second frame values 16..31, sof only on the first → 8 windows. The second frame's first window is {16,17,18,20,21,22,24,25,26}, and two frame_done pulses are issued.
- sof mid-frame: 4×4 stream, then re-assert sof at pixel 7 and send 0..15 → no windows from the aborted frame. The next 4 windows match the basic case.
- Reset mid-frame: assert rst_n=0 after pixel 11's window → win_valid, frame_done and win* read 0 immediately. A fresh 0..15 stream after release reproduces the basic case.
- Signed extremes: 28×28 defaults, pixels alternating -128/127 → 676 windows. Sign bits match a golden model, and frame_done asserts exactly once.
